cipher_arbiter: RTL and testbench
=================================

// Module: cipher_arbiter
// PURPOSE
//  Shares one cipher_core between two requester streams (ch0, ch1). Round-robin
//  arbitration of data beats onto core vin/tin/din. Serialises key/IV beats
//  behind a full pipeline drain. Tracks in-flight beats in an ID FIFO and routes
//  core vout/tout/dout back to the owning channel. Sits between stream
//  front-ends and cipher_core.
// PARAMETERS
//  FIFO_DEPTH  16  max in-flight data beats; power of 2, >= core pipeline depth
//  FIFO_AW     4   log2(FIFO_DEPTH)
//  STAT_W      32  beat-counter width (CIPHER_ARB_STATS_EN only)
// PORTS
//  clk           in   1    clock; all logic on posedge
//  rst_n         in   1    asynchronous, active-low reset
//  reqN_valid    in   1    N=0,1: beat offered
//  reqN_ready    out  1    beat accepted this cycle (comb from arb state)
//  reqN_type     in   2    00 enc, 01 dec, 10 key, 11 IV
//  reqN_data     in   128  beat payload
//  core_ready    in   1    cipher_core crypto_ready
//  core_vin      out  1    to cipher_core vin
//  core_tin      out  2    to cipher_core tin
//  core_din      out  128  to cipher_core din
//  core_vout     in   1    from cipher_core vout
//  core_tout     in   1    from cipher_core tout
//  core_dout     in   128  from cipher_core dout
//  rspN_valid    out  1    N=0,1: result beat (no backpressure)
//  rspN_type     out  1    0 enc, 1 dec
//  rspN_data     out  128  result
//  err_orphan    out  1    sticky: core_vout seen with ID FIFO empty
// BEHAVIOUR
//  Reset: all outputs 0; state RUN; rr pointer = ch0 favoured; FIFO empty;
//   count=0.
//  FSM: RUN  - grant data beats (type[1]=0) if core_ready & count<FIFO_DEPTH.
//              Winner's head is key/IV (type[1]=1) -> go DRAIN, lock winner.
//       DRAIN- no grants; wait count==0 -> CFG.
//       CFG  - if core_ready, assert locked reqN_ready for one key/IV beat ->
//              RUN. core_ready low holds CFG.
//  Arbitration: both valid -> channel != last granted; one valid -> it. Key/IV
//   heads arbitrate identically. rr pointer updates only on handshake.
//  Issue: handshake (valid&ready) at cycle T -> core_vin=1, core_tin=type,
//   core_din=data at T+1 (registered); else core_vin=0, core_din=0.
//  At most one handshake per cycle total.
//  ID FIFO: push granted channel ID on data-beat issue only (key/IV produce no
//   core output). Pop on core_vout. count = entries; simultaneous push+pop ->
//   count unchanged. count==FIFO_DEPTH -> no data grants.
//  Response: core_vout at T -> rspID_valid=1, rspID_type=core_tout,
//   rspID_data=core_dout at T+1; other channel valid=0, data=0.
//  Orphan: core_vout with FIFO empty -> beat dropped, err_orphan=1 until reset.
//  core_ready falls in RUN: grants stop; in-flight beats still routed.
//  rst_n low mid-operation: immediate clear of all state and outputs; in-flight
//   beats lost; post-reset core outputs counted as orphans.
//  ID FIFO wrap: pointers are FIFO_AW bits, wrap mod FIFO_DEPTH.
// CONFIGURATION
//  CIPHER_ARB_STATS_EN defined: extra outputs statN_beats[STAT_W-1:0] (N=0,1).
//   +1 per rspN_valid. Wrap at 2^STAT_W. Reset 0.
//  Undefined: ports and counters absent; other behaviour identical.
// TESTING
//  T1 ch0 enc beats A,B,C back-to-back, ch1 idle -> core_vin 3 cycles; rsp0
//     returns results in order; rsp1_valid never 1.
//  T2 ch0,ch1 both stream enc -> grants alternate 0,1,0,1; each rspN_data
//     matches its own din sequence (ECB).
//  T3 ch1 head IV with 5 beats in flight -> DRAIN until count=0, then one IV
//     beat on core_tin=11, back to RUN; no rsp generated for IV.
//  T4 FIFO_DEPTH=4, core_vout held off -> exactly 4 grants, reqN_ready=0 until
//     first core_vout; push+pop same cycle keeps count=4.
//  T5 inject core_vout with empty FIFO -> err_orphan=1, no rsp; stays 1 until
//     rst_n low.
//  T6 rst_n low with 3 in flight -> all outputs 0 same cycle; STATS_EN build:
//     statN_beats=0.

Source files
------------

// File: rtl/cipher_arbiter_if.sv
// Requester stream bundle for cipher_arbiter: request beats in, response beats out.
// master = stream front-end, slave = arbiter.
interface cipher_arbiter_if;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_type;
  logic [127:0] req_data;
  logic         rsp_valid;
  logic         rsp_type;
  logic [127:0] rsp_data;

  modport master (
    output req_valid, req_type, req_data,
    input  req_ready, rsp_valid, rsp_type, rsp_data
  );

  modport slave (
    input  req_valid, req_type, req_data,
    output req_ready, rsp_valid, rsp_type, rsp_data
  );
endinterface

// File: rtl/cipher_arbiter.sv
// Round-robin sharing of one cipher_core between two request streams, with key/IV
// beats serialised behind a pipeline drain. Optional CIPHER_ARB_STATS_EN adds beat counters.
module cipher_arbiter #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
`ifdef CIPHER_ARB_STATS_EN
  ,
  parameter int STAT_W     = 32
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  cipher_arbiter_if.slave ch0,
  cipher_arbiter_if.slave ch1,
  input  logic           core_ready,
  output logic           core_vin,
  output logic [1:0]     core_tin,
  output logic [127:0]   core_din,
  input  logic           core_vout,
  input  logic           core_tout,
  input  logic [127:0]   core_dout,
  output logic           err_orphan
`ifdef CIPHER_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat0_beats,
  output logic [STAT_W-1:0] stat1_beats
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, CFG} state_t;

  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

  state_t             state_reg;
  logic               last_reg;
  logic               lock_reg;
  logic [FIFO_AW:0]   count_reg;
  logic [FIFO_AW-1:0] wr_ptr_reg;
  logic [FIFO_AW-1:0] rd_ptr_reg;
  logic               id_mem [FIFO_DEPTH];
  logic               core_vin_reg;
  logic [1:0]         core_tin_reg;
  logic [127:0]       core_din_reg;
  logic               err_orphan_reg;

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_type [2];
  logic [127:0] req_data [2];
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_type;
  logic [127:0] rsp_data [2];

  assign req_valid   = {ch1.req_valid, ch0.req_valid};
  assign req_type[0] = ch0.req_type;
  assign req_type[1] = ch1.req_type;
  assign req_data[0] = ch0.req_data;
  assign req_data[1] = ch1.req_data;

  assign ch0.req_ready = req_ready[0];
  assign ch1.req_ready = req_ready[1];
  assign ch0.rsp_valid = rsp_valid[0];
  assign ch1.rsp_valid = rsp_valid[1];
  assign ch0.rsp_type  = rsp_type[0];
  assign ch1.rsp_type  = rsp_type[1];
  assign ch0.rsp_data  = rsp_data[0];
  assign ch1.rsp_data  = rsp_data[1];

  logic win;
  logic win_valid;
  logic win_cfg;
  logic full;
  logic hs;
  logic hs_ch;
  logic push;
  logic pop;
  logic head_id;

  // With both channels offering, the one not granted last time wins.
  assign win       = (&req_valid) ? ~last_reg : req_valid[1];
  assign win_valid = |req_valid;
  assign win_cfg   = req_type[win][1];
  assign full      = (count_reg == DEPTH_C);

  always_comb begin
    req_ready = 2'b00;
    case (state_reg)
      RUN:     if (win_valid && !win_cfg && core_ready && !full) req_ready[win] = 1'b1;
      CFG:     if (core_ready) req_ready[lock_reg] = 1'b1;
      default: req_ready = 2'b00;
    endcase
    if (!rst_n) req_ready = 2'b00;
  end

  assign hs      = |(req_ready & req_valid);
  assign hs_ch   = req_ready[1];
  assign push    = hs && !req_type[hs_ch][1];
  assign pop     = core_vout && (count_reg != '0);
  assign head_id = id_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr_reg] <= hs_ch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RUN;
      last_reg       <= 1'b1;
      lock_reg       <= 1'b0;
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      core_vin_reg   <= 1'b0;
      core_tin_reg   <= 2'b00;
      core_din_reg   <= '0;
      err_orphan_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: if (win_valid && win_cfg) begin
          state_reg <= DRAIN;
          lock_reg  <= win;
        end
        DRAIN:   if (count_reg == '0) state_reg <= CFG;
        CFG:     if (hs) state_reg <= RUN;
        default: state_reg <= RUN;
      endcase

      if (hs) last_reg <= hs_ch;

      core_vin_reg <= hs;
      core_tin_reg <= hs ? req_type[hs_ch] : 2'b00;
      core_din_reg <= hs ? req_data[hs_ch] : '0;

      if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (FIFO_AW+1)'(1);
        2'b01:   count_reg <= count_reg - (FIFO_AW+1)'(1);
        default: count_reg <= count_reg;
      endcase

      // A result with nothing in flight has no owner; drop it and flag.
      if (core_vout && (count_reg == '0)) err_orphan_reg <= 1'b1;
    end
  end

  assign core_vin   = core_vin_reg;
  assign core_tin   = core_tin_reg;
  assign core_din   = core_din_reg;
  assign err_orphan = err_orphan_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic         valid_reg;
    logic         type_reg;
    logic [127:0] data_reg;
    logic         mine;

    assign mine = pop && (head_id == 1'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        type_reg  <= 1'b0;
        data_reg  <= '0;
      end else begin
        valid_reg <= mine;
        type_reg  <= mine ? core_tout : 1'b0;
        data_reg  <= mine ? core_dout : '0;
      end
    end

    assign rsp_valid[gi] = valid_reg;
    assign rsp_type[gi]  = type_reg;
    assign rsp_data[gi]  = data_reg;
  end

`ifdef CIPHER_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    logic [STAT_W-1:0] beats_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              beats_reg <= '0;
      else if (rsp_valid[gi])  beats_reg <= beats_reg + STAT_W'(1);
    end

    assign stat_cnt[gi] = beats_reg;
  end

  assign stat0_beats = stat_cnt[0];
  assign stat1_beats = stat_cnt[1];
`endif

endmodule

// File: tb/tb_cipher_arbiter.sv
// Directed bench for cipher_arbiter; the bench plays cipher_core, returning din ^ KEY_C.
module tb_cipher_arbiter;
  localparam logic [127:0] KEY_C = 128'h5a5a_5a5a_0f0f_0f0f_a5a5_a5a5_f0f0_f0f0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         core_ready = 1'b0;
  logic         core_vin;
  logic [1:0]   core_tin;
  logic [127:0] core_din;
  logic         core_vout = 1'b0;
  logic         core_tout = 1'b0;
  logic [127:0] core_dout = '0;
  logic         err_orphan;
`ifdef CIPHER_ARB_STATS_EN
  logic [31:0]  stat0_beats;
  logic [31:0]  stat1_beats;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cipher_arbiter_if ch0_if ();
  cipher_arbiter_if ch1_if ();

  cipher_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch0        (ch0_if),
    .ch1        (ch1_if),
    .core_ready (core_ready),
    .core_vin   (core_vin),
    .core_tin   (core_tin),
    .core_din   (core_din),
    .core_vout  (core_vout),
    .core_tout  (core_tout),
    .core_dout  (core_dout),
    .err_orphan (err_orphan)
`ifdef CIPHER_ARB_STATS_EN
    ,
    .stat0_beats(stat0_beats),
    .stat1_beats(stat1_beats)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input int ch, input logic v, input logic [1:0] t, input logic [127:0] d);
    if (ch == 0) begin
      ch0_if.req_valid = v; ch0_if.req_type = t; ch0_if.req_data = d;
    end else begin
      ch1_if.req_valid = v; ch1_if.req_type = t; ch1_if.req_data = d;
    end
  endtask

  function automatic logic rdy(input int ch);
    return (ch == 0) ? ch0_if.req_ready : ch1_if.req_ready;
  endfunction

  function automatic logic rv(input int ch);
    return (ch == 0) ? ch0_if.rsp_valid : ch1_if.rsp_valid;
  endfunction

  function automatic logic rt(input int ch);
    return (ch == 0) ? ch0_if.rsp_type : ch1_if.rsp_type;
  endfunction

  function automatic logic [127:0] rd(input int ch);
    return (ch == 0) ? ch0_if.rsp_data : ch1_if.rsp_data;
  endfunction

  task automatic core_rsp(input logic t, input logic [127:0] d);
    core_vout = 1'b1; core_tout = t; core_dout = d;
    step();
    core_vout = 1'b0; core_tout = 1'b0; core_dout = '0;
    $display("core result type=%0d data=%h -> rsp0=%0d rsp1=%0d err=%0d",
             t, d, ch0_if.rsp_valid, ch1_if.rsp_valid, err_orphan);
  endtask

  logic [127:0] t1_d [3];
  logic [127:0] t2_d [4];
  logic [1:0]   t2_t [4];
  int           t2_c [4];
  logic [127:0] x_d  [6];
  logic [127:0] iv;
  logic [127:0] f_d;

  initial begin
    t1_d = '{128'hA0, 128'hB1, 128'hC2};
    t2_d = '{128'h1E0, 128'h0D0, 128'h1E1, 128'h0D1};
    t2_t = '{2'b00, 2'b01, 2'b00, 2'b01};
    t2_c = '{1, 0, 1, 0};
    for (int i = 0; i < 6; i++) x_d[i] = 128'h3000 + 128'(i);
    iv  = 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF;
    f_d = 128'h4444;

    // Reset state, with ch0 already offering so ready must be held low.
    drv(1, 1'b0, 2'b00, '0);
    core_ready = 1'b1;
    drv(0, 1'b1, 2'b00, t1_d[0]);
    repeat (2) step();
    #1;
    chk("rst_ready0", ch0_if.req_ready, 0);
    chk("rst_vin", core_vin, 0);
    chk("rst_din", core_din, 0);
    chk("rst_rsp0", ch0_if.rsp_valid, 0);
    chk("rst_rsp1", ch1_if.rsp_valid, 0);
    chk("rst_err", err_orphan, 0);
    rst_n = 1'b1;
    #1;
    chk("t1_ready0", ch0_if.req_ready, 1);
    chk("t1_ready1", ch1_if.req_ready, 0);

    // T1: ch0 back-to-back A,B,C.
    for (int i = 0; i < 3; i++) begin
      drv(0, 1'b1, 2'b00, t1_d[i]);
      step();
      chk("t1_vin", core_vin, 1);
      chk("t1_tin", core_tin, 0);
      chk("t1_din", core_din, t1_d[i]);
    end
    drv(0, 1'b0, 2'b00, '0);
    step();
    chk("t1_vin_idle", core_vin, 0);
    chk("t1_din_idle", core_din, 0);
    for (int i = 0; i < 3; i++) begin
      core_rsp(1'b0, t1_d[i] ^ KEY_C);
      chk("t1_rsp0_valid", ch0_if.rsp_valid, 1);
      chk("t1_rsp0_data", ch0_if.rsp_data, t1_d[i] ^ KEY_C);
      chk("t1_rsp1_valid", ch1_if.rsp_valid, 0);
    end
    step();
    chk("t1_rsp0_idle", ch0_if.rsp_valid, 0);

    // T2: both stream; ch0 was granted last, so ch1 goes first and they alternate.
    drv(1, 1'b1, t2_t[0], t2_d[0]);
    drv(0, 1'b1, t2_t[1], t2_d[1]);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_ready_win", rdy(t2_c[i]), 1);
      chk("t2_ready_lose", rdy(1 - t2_c[i]), 0);
      step();
      chk("t2_din", core_din, t2_d[i]);
      chk("t2_tin", core_tin, t2_t[i]);
      if (i + 2 < 4) drv(t2_c[i], 1'b1, t2_t[i+2], t2_d[i+2]);
      else           drv(t2_c[i], 1'b0, 2'b00, '0);
    end
    for (int i = 0; i < 4; i++) begin
      core_rsp(t2_t[i][0], t2_d[i] ^ KEY_C);
      chk("t2_rsp_valid", rv(t2_c[i]), 1);
      chk("t2_rsp_type", rt(t2_c[i]), t2_t[i][0]);
      chk("t2_rsp_data", rd(t2_c[i]), t2_d[i] ^ KEY_C);
      chk("t2_other_valid", rv(1 - t2_c[i]), 0);
      chk("t2_other_data", rd(1 - t2_c[i]), 0);
    end
    step();
`ifdef CIPHER_ARB_STATS_EN
    chk("t2_stat0", stat0_beats, 5);
    chk("t2_stat1", stat1_beats, 2);
`endif

    // T3: five ch0 beats in flight, then ch1 offers an IV while ch0 keeps offering data.
    for (int i = 0; i < 5; i++) begin
      drv(0, 1'b1, 2'b00, x_d[i]);
      step();
      chk("t3_fill_din", core_din, x_d[i]);
    end
    drv(0, 1'b1, 2'b00, x_d[5]);
    drv(1, 1'b1, 2'b11, iv);
    #1;
    chk("t3_iv_ready0", ch0_if.req_ready, 0);
    chk("t3_iv_ready1", ch1_if.req_ready, 0);
    step();
    chk("t3_drain_vin", core_vin, 0);
    for (int i = 0; i < 5; i++) begin
      core_vout = 1'b1; core_tout = 1'b0; core_dout = x_d[i] ^ KEY_C;
      #1;
      chk("t3_drain_ready0", ch0_if.req_ready, 0);
      chk("t3_drain_ready1", ch1_if.req_ready, 0);
      step();
      chk("t3_rsp0_data", ch0_if.rsp_data, x_d[i] ^ KEY_C);
      $display("drain result %0d data=%h", i, ch0_if.rsp_data);
    end
    core_vout = 1'b0; core_dout = '0;
    #1;
    chk("t3_empty_ready1", ch1_if.req_ready, 0);
    step();
    #1;
    chk("t3_cfg_ready1", ch1_if.req_ready, 1);
    chk("t3_cfg_ready0", ch0_if.req_ready, 0);
    step();
    chk("t3_iv_vin", core_vin, 1);
    chk("t3_iv_tin", core_tin, 3);
    chk("t3_iv_din", core_din, iv);
    drv(1, 1'b0, 2'b00, '0);
    #1;
    chk("t3_run_ready0", ch0_if.req_ready, 1);
    step();
    chk("t3_x5_din", core_din, x_d[5]);
    drv(0, 1'b0, 2'b00, '0);
    core_rsp(1'b0, x_d[5] ^ KEY_C);
    chk("t3_x5_rsp0", ch0_if.rsp_valid, 1);
    chk("t3_x5_rsp1", ch1_if.rsp_valid, 0);
    chk("t3_x5_data", ch0_if.rsp_data, x_d[5] ^ KEY_C);

    // T5: the IV left no ID behind, so this result is an orphan.
    chk("t5_err_before", err_orphan, 0);
    core_rsp(1'b0, 128'h0BAD);
    chk("t5_err", err_orphan, 1);
    chk("t5_rsp0", ch0_if.rsp_valid, 0);
    chk("t5_rsp1", ch1_if.rsp_valid, 0);
    step();
    chk("t5_err_sticky", err_orphan, 1);

    // T4: core_ready low blocks grants; then fill the ID FIFO to its depth of 16.
    core_ready = 1'b0;
    drv(0, 1'b1, 2'b00, f_d);
    #1;
    chk("t4_core_busy_ready0", ch0_if.req_ready, 0);
    core_ready = 1'b1;
    #1;
    chk("t4_core_ready_ready0", ch0_if.req_ready, 1);
    repeat (16) step();
    #1;
    chk("t4_full_ready0", ch0_if.req_ready, 0);
    step();
    core_vout = 1'b1; core_dout = f_d ^ KEY_C;
    #1;
    chk("t4_full_pop_ready0", ch0_if.req_ready, 0);
    step();
    #1;
    chk("t4_after_pop_ready0", ch0_if.req_ready, 1);
    step();
    core_vout = 1'b0;
    #1;
    chk("t4_pushpop_ready0", ch0_if.req_ready, 1);
    step();
    #1;
    chk("t4_refull_ready0", ch0_if.req_ready, 0);

    // T6: asynchronous reset mid-operation.
    core_vout = 1'b1;
    step();
    step();
    chk("t6_pre_vin", core_vin, 1);
    chk("t6_pre_rsp0", ch0_if.rsp_valid, 1);
    chk("t6_pre_err", err_orphan, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_vin", core_vin, 0);
    chk("t6_din", core_din, 0);
    chk("t6_tin", core_tin, 0);
    chk("t6_rsp0_valid", ch0_if.rsp_valid, 0);
    chk("t6_rsp0_data", ch0_if.rsp_data, 0);
    chk("t6_err", err_orphan, 0);
    chk("t6_ready0", ch0_if.req_ready, 0);
`ifdef CIPHER_ARB_STATS_EN
    chk("t6_stat0", stat0_beats, 0);
    chk("t6_stat1", stat1_beats, 0);
`endif
    core_vout = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_post_ready0", ch0_if.req_ready, 1);
    core_rsp(1'b0, 128'h7777);
    chk("t6_post_orphan", err_orphan, 1);
    chk("t6_post_rsp0", ch0_if.rsp_valid, 0);
    chk("t6_post_vin", core_vin, 1);
    drv(0, 1'b0, 2'b00, '0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
